// File: rtl/ft_pkg.sv
// Shared fault-tolerance definitions: restore FSM states and default sizing.
package ft_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int NUM_REGS_DEF    = 32;
    localparam int ACK_TIMEOUT_DEF = 64;

    localparam logic [7:0] RESTORE_CNT_MAX = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_COPY,
        ST_RELEASE,
        ST_FAIL
    } restore_state_t;

endpackage

// File: rtl/sgpr_restore.sv
// Lockstep recovery: on a comparator mismatch, halt both cores and copy shadow GPRs 1..N-1 back.
// Latency: first write 2 cycles after error_i when halt_ack_i is immediate; resume_o after NUM_REGS+1.
// Backpressure: waits on halt_ack_i (bounded by ACK_TIMEOUT, then sticky fail); copy is never stalled.
module sgpr_restore
    import ft_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  error_i,
    output logic                  halt_req_o,
    input  logic                  halt_ack_i,
    output logic [AW-1:0]         raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  we_o,
    output logic [AW-1:0]         waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  busy_o,
    output logic                  resume_o,
    output logic                  fail_o,
    output logic [7:0]            restore_cnt_o
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    restore_state_t state, state_nxt;
    logic [AW-1:0]  index, index_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic           halt_nxt;
    logic           resume_nxt;
    logic [7:0]     cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            index         <= '0;
            timer         <= '0;
            halt_req_o    <= 1'b0;
            resume_o      <= 1'b0;
            restore_cnt_o <= 8'd0;
        end else begin
            state         <= state_nxt;
            index         <= index_nxt;
            timer         <= timer_nxt;
            halt_req_o    <= halt_nxt;
            resume_o      <= resume_nxt;
            restore_cnt_o <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        index_nxt  = '0;
        timer_nxt  = timer;
        resume_nxt = 1'b0;
        cnt_nxt    = restore_cnt_o;
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (error_i) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                if (halt_ack_i) begin
                    state_nxt = ST_COPY;
                    index_nxt = AW'(1);
                end else begin
                    timer_nxt = timer + TW'(1);
                    if (timer == TIMER_LAST) state_nxt = ST_FAIL;
                end
            end
            ST_COPY: begin
                if (index == LAST_IDX) begin
                    state_nxt  = ST_RELEASE;
                    resume_nxt = 1'b1;
                    if (restore_cnt_o != RESTORE_CNT_MAX) cnt_nxt = restore_cnt_o + 8'd1;
                end else begin
                    index_nxt = index + AW'(1);
                end
            end
            ST_RELEASE: begin
                if (!halt_ack_i) state_nxt = ST_IDLE;
            end
            ST_FAIL: state_nxt = ST_FAIL;
            default: state_nxt = ST_IDLE;
        endcase
        // Registered so halt_req_o is glitch-free toward both cores.
        halt_nxt = (state_nxt == ST_HALT) || (state_nxt == ST_COPY) || (state_nxt == ST_FAIL);
    end

    always_comb begin
        raddr_o = '0;
        waddr_o = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        if (state == ST_COPY) begin
            raddr_o = index;
            waddr_o = index;
            wdata_o = rdata_i;
            we_o    = 1'b1;
        end
    end

    assign busy_o = (state != ST_IDLE);
    assign fail_o = (state == ST_FAIL);

endmodule

// File: tb/tb_sgpr_restore.sv
// Scoreboarded bench for sgpr_restore: expected GPR writes queued at stimulus, compared against observed writes.
module tb_sgpr_restore;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AT = 64;
    localparam int AW = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          error_i = 1'b0;
    logic          halt_ack_i = 1'b0;
    logic          halt_req_o;
    logic [AW-1:0] raddr_o;
    logic [DW-1:0] rdata_i;
    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [DW-1:0] wdata_o;
    logic          busy_o;
    logic          resume_o;
    logic          fail_o;
    logic [7:0]    restore_cnt_o;

    sgpr_restore #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .rst_n(rst_n), .error_i(error_i), .halt_req_o(halt_req_o),
        .halt_ack_i(halt_ack_i), .raddr_o(raddr_o), .rdata_i(rdata_i), .we_o(we_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o), .resume_o(resume_o),
        .fail_o(fail_o), .restore_cnt_o(restore_cnt_o)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] shadow [NR];
    assign rdata_i = shadow[raddr_o];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  res_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (we_o) begin
            w.addr = waddr_o;
            w.data = wdata_o;
            w.cyc  = cyc;
            obs_q.push_back(w);
        end
        if (resume_o) res_q.push_back(cyc);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        error_i = 1'b0;
        halt_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        res_q.delete();
    endtask

    task automatic fill_expected(input int c0);
        wr_t w;
        exp_q.delete();
        for (int i = 1; i < NR; i++) begin
            w.addr = AW'(i);
            w.data = 32'(i) * 32'h1111_1111;
            w.cyc  = c0 + 1 + i;
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_resume(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (resume_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (halt_req_o !== 1'b0) $display("FAIL reset_halt_req: got %b want 0", halt_req_o); else passed++;
        checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
        checks++; if (we_o !== 1'b0 || raddr_o !== '0) $display("FAIL reset_we_raddr: got we=%b raddr=%0d want 0/0", we_o, raddr_o); else passed++;
        checks++; if (resume_o !== 1'b0 || fail_o !== 1'b0) $display("FAIL reset_resume_fail: got %b/%b want 0/0", resume_o, fail_o); else passed++;
        checks++; if (restore_cnt_o !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", restore_cnt_o); else passed++;
        do_reset();
    endtask

    task automatic test_basic_restore();
        int c0;
        bit ok;
        do_reset();
        @(negedge clk);
        error_i = 1'b1;
        halt_ack_i = 1'b1;
        c0 = cyc;
        fill_expected(c0);
        @(negedge clk);
        error_i = 1'b0;
        checks++; if (halt_req_o !== 1'b1) $display("FAIL basic_halt_req: got %b want 1 one cycle after error", halt_req_o); else passed++;
        wait_resume(60, ok);
        checks++; if (!ok) $display("FAIL basic_resume_timeout: resume_o not seen within 60 cycles"); else passed++;
        halt_ack_i = 1'b0;
        wait_idle(10, ok);
        checks++; if (!ok) $display("FAIL basic_idle_timeout: busy_o still high"); else passed++;
        checks++; if (obs_q.size() != NR - 1) $display("FAIL basic_wr_count: got %0d want %0d", obs_q.size(), NR - 1); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size())
                $display("FAIL basic_wr[%0d]: missing, want addr %0d data %h cyc %0d", i, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            else if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data || obs_q[i].cyc != exp_q[i].cyc)
                $display("FAIL basic_wr[%0d]: got addr %0d data %h cyc %0d want addr %0d data %h cyc %0d", i,
                         obs_q[i].addr, obs_q[i].data, obs_q[i].cyc - c0, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc - c0);
            else passed++;
        end
        checks++; if (res_q.size() != 1) $display("FAIL basic_resume_count: got %0d want 1", res_q.size()); else passed++;
        checks++; if (res_q.size() > 0 && res_q[0] != c0 + NR + 1) $display("FAIL basic_resume_latency: got %0d want %0d", res_q[0] - c0, NR + 1); else passed++;
        checks++; if (restore_cnt_o !== 8'd1) $display("FAIL basic_cnt: got %0d want 1", restore_cnt_o); else passed++;
        checks++; if (halt_req_o !== 1'b0) $display("FAIL basic_halt_release: got %b want 0", halt_req_o); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        error_i = 1'b1;
        @(negedge clk);
        error_i = 1'b0;
        repeat (AT - 1) @(negedge clk);
        checks++; if (fail_o !== 1'b0 || halt_req_o !== 1'b1) $display("FAIL timeout_early: got fail=%b halt=%b want 0/1 after %0d halt cycles", fail_o, halt_req_o, AT); else passed++;
        @(negedge clk);
        checks++; if (fail_o !== 1'b1) $display("FAIL timeout_fail: got %b want 1", fail_o); else passed++;
        error_i = 1'b1;
        halt_ack_i = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (fail_o !== 1'b1 || halt_req_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL timeout_sticky: got fail=%b halt=%b busy=%b want 1/1/1", fail_o, halt_req_o, busy_o); else passed++;
        checks++; if (obs_q.size() != 0) $display("FAIL timeout_no_write: got %0d writes want 0", obs_q.size()); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (fail_o !== 1'b0 || halt_req_o !== 1'b0) $display("FAIL timeout_reset_clear: got fail=%b halt=%b want 0/0", fail_o, halt_req_o); else passed++;
        do_reset();
    endtask

    task automatic test_error_held();
        bit ok;
        do_reset();
        error_i = 1'b1;
        halt_ack_i = 1'b1;
        wait_resume(60, ok);
        checks++; if (!ok) $display("FAIL held_resume1_timeout: resume_o not seen"); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (busy_o !== 1'b1 || obs_q.size() != NR - 1) $display("FAIL held_single: got busy=%b writes=%0d want 1/%0d", busy_o, obs_q.size(), NR - 1); else passed++;
        checks++; if (restore_cnt_o !== 8'd1 || res_q.size() != 1) $display("FAIL held_cnt1: got cnt=%0d resumes=%0d want 1/1", restore_cnt_o, res_q.size()); else passed++;
        halt_ack_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) $display("FAIL held_idle: got busy=%b want 0", busy_o); else passed++;
        @(negedge clk);
        checks++; if (halt_req_o !== 1'b1) $display("FAIL held_restart: got halt=%b want 1", halt_req_o); else passed++;
        halt_ack_i = 1'b1;
        wait_resume(60, ok);
        checks++; if (!ok) $display("FAIL held_resume2_timeout: resume_o not seen"); else passed++;
        error_i = 1'b0;
        halt_ack_i = 1'b0;
        wait_idle(10, ok);
        checks++; if (!ok || restore_cnt_o !== 8'd2 || obs_q.size() != 2 * (NR - 1)) $display("FAIL held_second: got idle=%b cnt=%0d writes=%0d want 1/2/%0d", ok, restore_cnt_o, obs_q.size(), 2 * (NR - 1)); else passed++;
    endtask

    task automatic test_reset_mid_copy();
        int n;
        do_reset();
        n = 0;
        error_i = 1'b1;
        halt_ack_i = 1'b1;
        @(negedge clk);
        error_i = 1'b0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            @(negedge clk);
            if (we_o) n++;
        end
        checks++; if (n != 10) $display("FAIL midrst_reach: got %0d copy cycles want 10", n); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (we_o !== 1'b0 || waddr_o !== '0 || wdata_o !== '0 || raddr_o !== '0) $display("FAIL midrst_wr_zero: got we=%b waddr=%0d wdata=%h", we_o, waddr_o, wdata_o); else passed++;
        checks++; if (halt_req_o !== 1'b0 || busy_o !== 1'b0 || resume_o !== 1'b0 || restore_cnt_o !== 8'd0) $display("FAIL midrst_ctrl_zero: got halt=%b busy=%b resume=%b cnt=%0d", halt_req_o, busy_o, resume_o, restore_cnt_o); else passed++;
        halt_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (res_q.size() != 0 || obs_q.size() != 10) $display("FAIL midrst_aftermath: got resumes=%0d writes=%0d want 0/10", res_q.size(), obs_q.size()); else passed++;
    endtask

    task automatic test_ack_drop();
        int n;
        bit ok;
        do_reset();
        n = 0;
        error_i = 1'b1;
        halt_ack_i = 1'b1;
        fill_expected(cyc);
        @(negedge clk);
        error_i = 1'b0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            if (we_o) n++;
        end
        halt_ack_i = 1'b0;
        wait_resume(60, ok);
        checks++; if (!ok) $display("FAIL ackdrop_resume_timeout: resume_o not seen"); else passed++;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) $display("FAIL ackdrop_exit: got busy=%b want 0", busy_o); else passed++;
        checks++; if (obs_q.size() != NR - 1) $display("FAIL ackdrop_wr_count: got %0d want %0d", obs_q.size(), NR - 1); else passed++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data)
                $display("FAIL ackdrop_wr[%0d]: got addr %0d data %h want addr %0d data %h", i, obs_q[i].addr, obs_q[i].data, exp_q[i].addr, exp_q[i].data);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int misses;
        do_reset();
        misses = 0;
        for (int k = 0; k < 256; k++) begin
            error_i = 1'b1;
            halt_ack_i = 1'b1;
            @(negedge clk);
            error_i = 1'b0;
            wait_resume(60, ok);
            if (!ok) misses++;
            halt_ack_i = 1'b0;
            wait_idle(10, ok);
            if (!ok) misses++;
            if (k == 253) begin
                checks++; if (restore_cnt_o !== 8'd254) $display("FAIL b2b_cnt254: got %0d want 254", restore_cnt_o); else passed++;
            end
            if (k == 254) begin
                checks++; if (restore_cnt_o !== 8'd255) $display("FAIL b2b_cnt255: got %0d want 255", restore_cnt_o); else passed++;
            end
        end
        checks++; if (misses != 0) $display("FAIL b2b_timeouts: got %0d bounded waits expired want 0", misses); else passed++;
        checks++; if (restore_cnt_o !== 8'd255) $display("FAIL b2b_saturate: got %0d want 255", restore_cnt_o); else passed++;
        checks++; if (res_q.size() != 256) $display("FAIL b2b_resumes: got %0d want 256", res_q.size()); else passed++;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) shadow[i] = 32'(i) * 32'h1111_1111;
        test_reset();
        test_basic_restore();
        test_timeout();
        test_error_held();
        test_reset_mid_copy();
        test_ack_drop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", passed, checks);
        $fatal(1);
    end

endmodule
